img_rom_arbiter: RTL and testbench

IMG_ROM_ARBITER -- requirements
Module: img_rom_arbiter

---
 rtl/img_rom_pkg.sv | 16 +
 rtl/img_rom_arbiter_if.sv | 27 ++
 rtl/img_rom_arbiter_rr_pick.sv | 22 ++
 rtl/img_rom_arbiter.sv | 85 ++++++++
 tb/tb_img_rom_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/img_rom_pkg.sv
// Shared constants for the image-ROM arbiter slice: default geometry and scene codes.
package img_rom_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int ADDR_W_DEF  = 17;
    localparam int DATA_W_DEF  = 12;
    localparam int ROM_LAT_DEF = 2;

    typedef enum logic [3:0] {
        START  = 4'b0001,
        CHOOSE = 4'b0010,
        FIGHT  = 4'b0011,
        WIN    = 4'b0100
    } scene_e;

endpackage

// File: rtl/img_rom_arbiter_if.sv
// Requester/ROM bus of the image-ROM arbiter; master = requesters + ROM, slave = arbiter.
interface img_rom_arbiter_if
    import img_rom_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic                    flush;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]       rom_addr;
    logic [DATA_W-1:0]       rom_data;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;

    modport master (
        output flush, req, req_addr, rom_data,
        input  gnt, rom_addr, rsp_valid, rsp_data
    );

    modport slave (
        input  flush, req, req_addr, rom_data,
        output gnt, rom_addr, rsp_valid, rsp_data
    );
endinterface

// File: rtl/img_rom_arbiter_rr_pick.sv
// Rotating-mask priority encoder: first set req bit at or above ptr, else wrap to lowest.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt
);
    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] src;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
        assign mask[gi] = (PTR_W'(gi) >= ptr);
    end

    assign masked = req & mask;
    assign src    = (|masked) ? masked : req;
    // Isolate the lowest set bit of the chosen vector.
    assign gnt    = src & (~src + N_REQ'(1));
endmodule

// File: rtl/img_rom_arbiter.sv
// Round-robin arbiter for the shared image ROM with an in-flight tag pipe.
// Define ROM_ARB_PRIO_EN to give requester 0 (VGA pixel path) absolute priority.
module img_rom_arbiter
    import img_rom_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    img_rom_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]              ptr_q, ptr_d;
    logic [ADDR_W-1:0]             rom_addr_q, rom_addr_d;
    logic [ROM_LAT:0][N_REQ-1:0]   tag_q;
    logic [N_REQ-1:0]              rr_req, rr_gnt, gnt;

`ifdef ROM_ARB_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
    assign rr_req = {bus.req[N_REQ-1:1], 1'b0};
    assign gnt    = bus.flush  ? '0 :
                    bus.req[0] ? N_REQ'(1) : rr_gnt;
`else
    localparam bit PRIO_EN = 1'b0;
    assign rr_req = bus.req;
    assign gnt    = bus.flush ? '0 : rr_gnt;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req (rr_req),
        .ptr (ptr_q),
        .gnt (rr_gnt)
    );

    always_comb begin
        ptr_d      = ptr_q;
        rom_addr_d = rom_addr_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt[k]) begin
                rom_addr_d = bus.req_addr[k*ADDR_W +: ADDR_W];
                // The priority requester is outside the rotation and leaves ptr alone.
                if (!(PRIO_EN && k == 0)) begin
                    if (k == N_REQ - 1) ptr_d = '0;
                    else                ptr_d = PTR_W'(k + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            rom_addr_q <= '0;
        end else if (!bus.flush) begin
            ptr_q      <= ptr_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    // Stage 0 holds the grant made last cycle; stage ROM_LAT lines up with rom_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= '0;
        end else if (bus.flush) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= gnt;
            for (int s = 1; s <= ROM_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign bus.gnt       = gnt;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.rsp_valid = tag_q[ROM_LAT];
    assign bus.rsp_data  = bus.rom_data;
endmodule

// File: tb/tb_img_rom_arbiter.sv
// Directed bench for img_rom_arbiter with a queue-based round-robin/latency model.
module tb_img_rom_arbiter;
    localparam int N   = 4;
    localparam int AW  = 17;
    localparam int DW  = 12;
    localparam int LAT = 2;
`ifdef ROM_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    typedef struct {
        int            due;
        int            k;
        logic [AW-1:0] a;
    } pend_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    img_rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    img_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        return a[11:0] ^ {a[16:12], 7'h2B};
    endfunction

    // Two-cycle ROM: data for an address appears LAT cycles after it is presented.
    logic [DW-1:0] rom_d1, rom_q;
    always @(posedge clk) begin
        rom_d1 <= rom_fn(bus.rom_addr);
        rom_q  <= rom_d1;
    end
    assign bus.rom_data = rom_q;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            m_ptr   = 0;
    logic [AW-1:0] m_addr  = '0;
    pend_t         pend[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] r, input logic f);
        if (f) return -1;
        if (PRIO && r[0]) return 0;
        for (int o = 0; o < N; o++) begin
            int k;
            k = (m_ptr + o) % N;
            if (PRIO && k == 0) continue;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [N*AW-1:0] addrs(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                              input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_addr = '0;
        pend.delete();
    endtask

    // One clock cycle: drive, compare against the model mid-cycle, advance the model.
    task automatic step(input logic [N-1:0] r, input logic [N*AW-1:0] a, input logic f,
                        output logic [N-1:0] g_o, output logic [N-1:0] rv_o,
                        output logic [DW-1:0] rd_o);
        int            k;
        logic [N-1:0]  exp_g, exp_rv;
        logic [DW-1:0] exp_rd;
        pend_t         keep[$];
        bus.req      = r;
        bus.req_addr = a;
        bus.flush    = f;
        @(negedge clk);
        k      = model_pick(r, f);
        exp_g  = (k >= 0) ? (N'(1) << k) : '0;
        exp_rv = '0;
        exp_rd = '0;
        foreach (pend[i]) begin
            if (pend[i].due == cyc) begin
                exp_rv = N'(1) << pend[i].k;
                exp_rd = rom_fn(pend[i].a);
            end
        end
        chk("gnt", 32'(bus.gnt), 32'(exp_g));
        chk("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
        if (exp_rv != '0) chk("rsp_data", 32'(bus.rsp_data), 32'(exp_rd));
        $display("[TB] cyc=%0d req=%b flush=%b gnt=%b rom_addr=%05h rsp_valid=%b rsp_data=%03h",
                 cyc, r, f, bus.gnt, bus.rom_addr, bus.rsp_valid, bus.rsp_data);
        g_o  = bus.gnt;
        rv_o = bus.rsp_valid;
        rd_o = bus.rsp_data;
        foreach (pend[i]) if (pend[i].due > cyc && !f) keep.push_back(pend[i]);
        pend = keep;
        if (k >= 0) begin
            m_addr = a[k*AW +: AW];
            pend.push_back('{cyc + 1 + LAT, k, m_addr});
            if (!(PRIO && k == 0)) m_ptr = (k + 1) % N;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    logic [N-1:0]     g, rv;
    logic [DW-1:0]    rd;
    logic [N-1:0]     g_log[8];
    logic [N-1:0]     rv_log[8];
    logic [N-1:0]     exp_seq[8];
    logic [N-1:0]     exp_pr[6];
    logic [N-1:0]     vec[8];
    logic [N*AW-1:0]  za;

    initial begin
        za           = '0;
        rst          = 1'b1;
        bus.flush    = 1'b0;
        bus.req      = '0;
        bus.req_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rom_addr", 32'(bus.rom_addr), 32'h0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("reset_gnt", 32'(bus.gnt), 32'h0);
        rst = 1'b0;
        model_reset();
        cyc = 0;

        // Single request in cycle 5.
        repeat (5) step(4'b0000, za, 1'b0, g, rv, rd);
        step(4'b0100, addrs(17'h0, 17'h0, 17'h00123, 17'h0), 1'b0, g, rv, rd);
        chk("single_gnt", 32'(g), 32'h4);
        chk("single_rom_addr", 32'(bus.rom_addr), 32'h00123);
        repeat (2) step(4'b0000, za, 1'b0, g, rv, rd);
        step(4'b0000, za, 1'b0, g, rv, rd);
        chk("single_rsp_valid", 32'(rv), 32'h4);
        chk("single_rsp_data", 32'(rd), 32'h108);

        // Full load from a fresh reset, then reset mid-burst.
        do_reset();
        exp_seq = PRIO ? '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1}
                       : '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, addrs(17'h00010 + 17'(i), 17'h01000 + 17'(i),
                                17'h02000 + 17'(i), 17'h1F000 + 17'(i)), 1'b0, g, rv, rd);
            g_log[i]  = g;
            rv_log[i] = rv;
        end
        for (int i = 0; i < 5; i++) chk("full_gnt_seq", 32'(g_log[i]), 32'(exp_seq[i]));
        for (int i = 0; i < 5; i++) chk("full_rsp_seq", 32'(rv_log[i+3]), 32'(exp_seq[i]));
        do_reset();
        step(4'b1111, addrs(17'h1, 17'h2, 17'h3, 17'h4), 1'b0, g, rv, rd);
        chk("post_reset_gnt", 32'(g), 32'h1);

        // Flush right after a grant to requester 1.
        repeat (3) step(4'b0000, za, 1'b0, g, rv, rd);
        step(4'b0010, addrs(17'h0, 17'h0ABC, 17'h0, 17'h0), 1'b0, g, rv, rd);
        chk("flush_pre_gnt", 32'(g), 32'h2);
        step(4'b1111, addrs(17'h5, 17'h6, 17'h7, 17'h8), 1'b1, g, rv, rd);
        chk("flush_gnt", 32'(g), 32'h0);
        step(4'b0000, za, 1'b0, g, rv, rd);
        chk("flush_rsp_a", 32'(rv), 32'h0);
        step(4'b0000, za, 1'b0, g, rv, rd);
        chk("flush_rsp_b", 32'(rv), 32'h0);
        step(4'b1111, addrs(17'h9, 17'hA, 17'hB, 17'hC), 1'b0, g, rv, rd);
        chk("flush_ptr_hold", 32'(g), PRIO ? 32'h1 : 32'h4);

        // Idle after a grant to requester 3.
        step(4'b1000, addrs(17'h0, 17'h0, 17'h0, 17'h1ABCD), 1'b0, g, rv, rd);
        chk("idle_pre_gnt", 32'(g), 32'h8);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, za, 1'b0, g, rv, rd);
            chk("idle_gnt", 32'(g), 32'h0);
            chk("idle_rom_addr", 32'(bus.rom_addr), 32'h1ABCD);
        end
        step(4'b1111, addrs(17'h11, 17'h22, 17'h33, 17'h44), 1'b0, g, rv, rd);
        chk("idle_next_gnt", 32'(g), 32'h1);

        // req=1111 then requester 0 drops out.
        exp_pr = PRIO ? '{4'h1, 4'h1, 4'h1, 4'h2, 4'h4, 4'h8}
                      : '{4'h2, 4'h4, 4'h8, 4'h2, 4'h4, 4'h8};
        for (int i = 0; i < 6; i++) begin
            step((i < 3) ? 4'b1111 : 4'b1110,
                 addrs(17'h100 + 17'(i), 17'h200 + 17'(i), 17'h300 + 17'(i), 17'h400 + 17'(i)),
                 1'b0, g, rv, rd);
            chk("prio_seq", 32'(g), 32'(exp_pr[i]));
        end

        // Mixed patterns with a flush in the middle, checked by the model only.
        vec = '{4'b0101, 4'b1010, 4'b0110, 4'b1001, 4'b0011, 4'b1100, 4'b0000, 4'b1111};
        for (int i = 0; i < 8; i++) begin
            step(vec[i], addrs(17'($urandom), 17'($urandom), 17'($urandom), 17'($urandom)),
                 (i == 4), g, rv, rd);
        end
        repeat (4) step(4'b0000, za, 1'b0, g, rv, rd);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
